lockstep_dmem_ctrl: RTL

Lockstep data-memory controller between the data ports of two redundant zeroriscy cores and the single port of one data mem_mod.
- Waits for both cores to issue a data request and checks that the requests are identical.
- Issues exactly one memory transaction and returns the grant and the response to both cores in the same cycle.
- Raises a sticky fault on request mismatch, excessive request skew between the cores, or protocol violation.

---
 rtl/lockstep_pkg.sv | 26 ++
 rtl/lockstep_req_cmp.sv | 28 ++
 rtl/lockstep_dmem_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared types for the lockstep data-memory controller.
// Rev 1.0
`default_nettype none

package lockstep_pkg;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PEER = 3'd1,
    REQ       = 3'd2,
    RESP      = 3'd3,
    FAULT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISMATCH = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_PROTOCOL = 2'b11
  } cause_t;

endpackage

`default_nettype wire

// File: rtl/lockstep_req_cmp.sv
// lockstep_req_cmp: combinational equality check of two core request field sets.
// Rev 1.0
`default_nettype none

module lockstep_req_cmp
  import lockstep_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              a_we_i,
  input  logic [BE_W-1:0]   a_be_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_we_i,
  input  logic [BE_W-1:0]   b_be_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              match_o
);

  // Write data only matters for writes; reads may carry stale wdata.
  assign match_o = (a_we_i == b_we_i) && (a_be_i == b_be_i) && (a_addr_i == b_addr_i) &&
                   (!a_we_i || (a_wdata_i == b_wdata_i));

endmodule

`default_nettype wire

// File: rtl/lockstep_dmem_ctrl.sv
// lockstep_dmem_ctrl: merges two redundant core data ports onto one memory port.
// Rev 1.0
`default_nettype none

module lockstep_dmem_ctrl
  import lockstep_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_SKEW = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c1_req_i,
  input  logic              c1_we_i,
  input  logic [BE_W-1:0]   c1_be_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [DATA_W-1:0] c1_wdata_i,
  output logic              c1_gnt_o,
  output logic              c1_rvalid_o,
  output logic [DATA_W-1:0] c1_rdata_o,
  input  logic              c2_req_i,
  input  logic              c2_we_i,
  input  logic [BE_W-1:0]   c2_be_i,
  input  logic [ADDR_W-1:0] c2_addr_i,
  input  logic [DATA_W-1:0] c2_wdata_i,
  output logic              c2_gnt_o,
  output logic              c2_rvalid_o,
  output logic [DATA_W-1:0] c2_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              clear_i,
  output logic              err_o,
  output logic [1:0]        fault_cause_o,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  localparam int SKEW_W = $clog2(MAX_SKEW + 1);

  state_t              state_q;
  cause_t              cause_q;
  cause_t              cause_d;
  logic                fault_d;
  logic [SKEW_W-1:0]   skew_cnt_q;
  logic                first_c2_q;
  logic                err_q;
  logic [CNT_W-1:0]    fault_cnt_q;
  logic [CNT_W-1:0]    fault_cnt_d;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                match;
  logic                first_req;
  logic                peer_req;
  logic                rvalid;

  lockstep_req_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_cmp (
    .a_we_i    (c1_we_i),
    .a_be_i    (c1_be_i),
    .a_addr_i  (c1_addr_i),
    .a_wdata_i (c1_wdata_i),
    .b_we_i    (c2_we_i),
    .b_be_i    (c2_be_i),
    .b_addr_i  (c2_addr_i),
    .b_wdata_i (c2_wdata_i),
    .match_o   (match)
  );

  assign first_req   = first_c2_q ? c2_req_i : c1_req_i;
  assign peer_req    = first_c2_q ? c1_req_i : c2_req_i;
  assign fault_cnt_d = (&fault_cnt_q) ? fault_cnt_q : fault_cnt_q + 1'b1;

  // Fault detection; a first-requester drop outranks a same-cycle peer arrival.
  always_comb begin
    fault_d = 1'b0;
    cause_d = CAUSE_NONE;
    case (state_q)
      IDLE: begin
        if (c1_req_i && c2_req_i && !match) begin
          fault_d = 1'b1;
          cause_d = CAUSE_MISMATCH;
        end
      end
      WAIT_PEER: begin
        if (!first_req) begin
          fault_d = 1'b1;
          cause_d = CAUSE_PROTOCOL;
        end else if (peer_req && !match) begin
          fault_d = 1'b1;
          cause_d = CAUSE_MISMATCH;
        end else if (!peer_req && (skew_cnt_q == SKEW_W'(MAX_SKEW))) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cause_q     <= CAUSE_NONE;
      skew_cnt_q  <= '0;
      first_c2_q  <= 1'b0;
      err_q       <= 1'b0;
      fault_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (fault_d) begin
      state_q     <= FAULT;
      cause_q     <= cause_d;
      err_q       <= 1'b1;
      fault_cnt_q <= fault_cnt_d;
      mem_req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c1_req_i && c2_req_i) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= c1_we_i;
            mem_be_q    <= c1_be_i;
            mem_addr_q  <= c1_addr_i;
            mem_wdata_q <= c1_wdata_i;
          end else if (c1_req_i || c2_req_i) begin
            state_q    <= WAIT_PEER;
            skew_cnt_q <= SKEW_W'(1);
            first_c2_q <= c2_req_i;
          end
        end
        WAIT_PEER: begin
          if (peer_req) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= c1_we_i;
            mem_be_q    <= c1_be_i;
            mem_addr_q  <= c1_addr_i;
            mem_wdata_q <= c1_wdata_i;
          end else begin
            skew_cnt_q <= skew_cnt_q + 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        FAULT: begin
          if (clear_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid = (state_q == RESP) && mem_rvalid_i;

  assign c1_gnt_o      = (state_q == REQ) && mem_gnt_i;
  assign c2_gnt_o      = (state_q == REQ) && mem_gnt_i;
  assign c1_rvalid_o   = rvalid;
  assign c2_rvalid_o   = rvalid;
  assign c1_rdata_o    = rvalid ? mem_rdata_i : '0;
  assign c2_rdata_o    = rvalid ? mem_rdata_i : '0;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign err_o         = err_q;
  assign fault_cause_o = cause_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule

`default_nettype wire
